// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: IF/ID bus layout,
// the injected NOP word and the boot/run state encoding.
package fetch_stage_pkg;

    localparam int INPORT_MSB = 68;
    localparam int ADDR_MSB   = 52;
    localparam int INSTR_MSB  = 20;
    localparam int INT_BIT    = 4;
    localparam int MEMRD_BIT  = 3;
    localparam int RDST_MSB   = 2;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        RUN     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter with boot-vector loading (high half, then low half)
// and the run-time next-PC selection: jump > stall > flush > increment.
module pc_register
    import fetch_stage_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [15:0]  instr_data_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         jump_i,
    input  logic [31:0]  jump_target_i,
    output fetch_state_e state_o,
    output logic [31:0]  pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT_HI;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Boot states ignore redirects; a flush or stall simply leaves the PC alone.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT_HI: begin
                pc_d    = {instr_data_i, pc_q[15:0]};
                state_d = BOOT_LO;
            end
            BOOT_LO: begin
                pc_d    = {pc_q[31:16], instr_data_i};
                state_d = RUN;
            end
            RUN: begin
                if (jump_i) begin
                    pc_d = jump_target_i;
                end else if (!stall_i && !flush_i) begin
                    pc_d = pc_q + 32'd1;
                end
            end
            default: begin
                state_d = BOOT_HI;
            end
        endcase
    end

    assign state_o = state_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives instruction memory, latches interrupts
// and produces the registered IF/ID bus for the decode stage.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               PC_W      = 32,
    parameter int               INSTR_W   = 16,
    parameter logic [PC_W-1:0]  BOOT_ADDR = '0
) (
    input  logic               Clk,
    input  logic               Rst,
    output logic [PC_W-1:0]    InstrAddr,
    input  logic [INSTR_W-1:0] InstrData,
    input  logic [INSTR_W-1:0] InPort,
    input  logic               IntReq,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               JumpTaken,
    input  logic [PC_W-1:0]    JumpTarget,
    input  logic               IdExMemRead,
    input  logic [2:0]         IdExRdst,
    output logic [68:0]        Out
);

    fetch_state_e       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pcPlusOne;

    logic [INSTR_W-1:0] inport_q, inport_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               tag_q, tag_d;
    logic               pending_q, pending_d;

    pc_register u_pc_register (
        .clk_i         (Clk),
        .rst_ni        (Rst),
        .instr_data_i  (InstrData),
        .stall_i       (Stall),
        .flush_i       (Flush),
        .jump_i        (JumpTaken),
        .jump_target_i (JumpTarget),
        .state_o       (state),
        .pc_o          (pc)
    );

    assign pcPlusOne = pc + PC_W'(1);

    always_comb begin
        InstrAddr = pc;
        unique case (state)
            BOOT_HI: InstrAddr = BOOT_ADDR;
            BOOT_LO: InstrAddr = BOOT_ADDR + PC_W'(1);
            default: ;
        endcase
    end

    // A pending interrupt rides only on a real fetched instruction; any NOP slot defers it.
    always_comb begin
        inport_d  = inport_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        tag_d     = tag_q;
        pending_d = pending_q | IntReq;
        if (state != RUN || JumpTaken) begin
            instr_d = NOP_WORD;
            tag_d   = 1'b0;
        end else if (!Stall) begin
            addr_d   = pcPlusOne;
            inport_d = InPort;
            if (Flush) begin
                instr_d = NOP_WORD;
                tag_d   = 1'b0;
            end else begin
                instr_d   = InstrData;
                tag_d     = pending_q;
                pending_d = IntReq;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            inport_q  <= '0;
            addr_q    <= '0;
            instr_q   <= NOP_WORD;
            tag_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            inport_q  <= inport_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            tag_q     <= tag_d;
            pending_q <= pending_d;
        end
    end

    assign Out[INPORT_MSB:ADDR_MSB+1] = inport_q;
    assign Out[ADDR_MSB:INSTR_MSB+1]  = addr_q;
    assign Out[INSTR_MSB:INT_BIT+1]   = instr_q;
    assign Out[INT_BIT]               = tag_q;
    assign Out[MEMRD_BIT]             = IdExMemRead;
    assign Out[RDST_MSB:0]            = IdExRdst;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed boot/stall/jump/interrupt/reset
// scenarios followed by randomized traffic against a behavioural model.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] InstrAddr;
    logic [15:0] InstrData;
    logic [15:0] InPort;
    logic        IntReq;
    logic        Stall;
    logic        Flush;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic        IdExMemRead;
    logic [2:0]  IdExRdst;
    logic [68:0] Out;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [15:0] bootHi = 16'h0000;
    logic [15:0] bootLo = 16'h0020;

    // Behavioural model of the stage
    int          bootStep;
    logic [31:0] mPc;
    logic        mPending;
    logic [15:0] mInport;
    logic [31:0] mAddr;
    logic [15:0] mInstr;
    logic        mTag;
    bit          mAddrValid;

    fetch_stage dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InstrAddr   (InstrAddr),
        .InstrData   (InstrData),
        .InPort      (InPort),
        .IntReq      (IntReq),
        .Stall       (Stall),
        .Flush       (Flush),
        .JumpTaken   (JumpTaken),
        .JumpTarget  (JumpTarget),
        .IdExMemRead (IdExMemRead),
        .IdExRdst    (IdExRdst),
        .Out         (Out)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] hashWord(input logic [31:0] a);
        return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] memModel(input logic [31:0] a);
        if (a == 32'd0) return bootHi;
        if (a == 32'd1) return bootLo;
        return hashWord(a);
    endfunction

    assign InstrData = (InstrAddr == 32'd0) ? bootHi :
                       (InstrAddr == 32'd1) ? bootLo : hashWord(InstrAddr);

    function automatic logic [31:0] modelAddr();
        if (bootStep == 0) return 32'd0;
        if (bootStep == 1) return 32'd1;
        return mPc;
    endfunction

    task automatic checkOutput(input string tag, input logic [68:0] observed,
                               input logic [68:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        bootStep   = 0;
        mPc        = 32'd0;
        mPending   = 1'b0;
        mInport    = 16'd0;
        mAddr      = 32'd0;
        mInstr     = 16'h0000;
        mTag       = 1'b0;
        mAddrValid = 1'b1;
    endtask

    task automatic modelClock();
        logic [15:0] word;
        word = memModel(modelAddr());
        if (bootStep < 2) begin
            if (bootStep == 0) mPc[31:16] = word;
            else               mPc[15:0]  = word;
            bootStep++;
            mInstr   = 16'h0000;
            mTag     = 1'b0;
            mPending = mPending || IntReq;
        end else if (JumpTaken) begin
            mPc        = JumpTarget;
            mInstr     = 16'h0000;
            mTag       = 1'b0;
            mAddrValid = 1'b0;
            mPending   = mPending || IntReq;
        end else if (Stall) begin
            mPending = mPending || IntReq;
        end else begin
            mAddr      = mPc + 32'd1;
            mInport    = InPort;
            mAddrValid = 1'b1;
            if (Flush) begin
                mInstr   = 16'h0000;
                mTag     = 1'b0;
                mPending = mPending || IntReq;
            end else begin
                mInstr   = word;
                mTag     = mPending;
                mPending = IntReq;
                mPc      = mPc + 32'd1;
            end
        end
    endtask

    task automatic checkState();
        checkOutput("instrAddr", 69'(InstrAddr), 69'(modelAddr()));
        checkOutput("passThru", 69'(Out[3:0]), 69'({IdExMemRead, IdExRdst}));
        if (mAddrValid)
            checkOutput("ifidBus", 69'(Out[68:4]), 69'({mInport, mAddr, mInstr, mTag}));
        else
            checkOutput("ifidInstrTag", 69'(Out[20:4]), 69'({mInstr, mTag}));
    endtask

    // Called just after a falling edge; drives one cycle of inputs and advances one rising edge.
    task automatic applyStimulus(input logic jmp, input logic stl, input logic fls,
                                 input logic irq, input logic [31:0] tgt);
        JumpTaken   = jmp;
        Stall       = stl;
        Flush       = fls;
        IntReq      = irq;
        JumpTarget  = tgt;
        InPort      = 16'($urandom);
        IdExMemRead = 1'($urandom);
        IdExRdst    = 3'($urandom);
        #1;
        checkState();
        @(posedge Clk);
        modelClock();
        @(negedge Clk);
    endtask

    task automatic resetMidCycle();
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("rstBus", 69'(Out[68:4]), 69'(0));
        checkOutput("rstAddr", 69'(InstrAddr), 69'(0));
        checkOutput("rstPass", 69'(Out[3:0]), 69'({IdExMemRead, IdExRdst}));
        modelReset();
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        Rst         = 1'b0;
        InPort      = 16'd0;
        IntReq      = 1'b0;
        Stall       = 1'b0;
        Flush       = 1'b0;
        JumpTaken   = 1'b0;
        JumpTarget  = 32'd0;
        IdExMemRead = 1'b1;
        IdExRdst    = 3'd5;
        modelReset();
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("resetBus", 69'(Out), 69'({65'd0, 1'b1, 3'd5}));
        Rst = 1'b1;

        // Boot from M[0]/M[1] to 0x20, then sequential fetch and a two-cycle stall
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Jump wins over stall, then interrupt raised during a flush
        applyStimulus(1, 1, 0, 0, 32'h100);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Back-to-back interrupt request on the fetch that consumes the previous one
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Reach PC 0x55, reset between edges, then reboot near the top of memory
        applyStimulus(1, 0, 0, 0, 32'h54);
        applyStimulus(0, 0, 0, 0, 0);
        IdExMemRead = 1'b1;
        IdExRdst    = 3'd5;
        resetMidCycle();
        bootHi = 16'hFFFF;
        bootLo = 16'hFFFE;
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetMidCycle();
            end else begin
                applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                              {24'd0, 8'($urandom)});
            end
        end
        #1;
        checkState();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
